ex_div_sequencer: RTL and testbench

//   Multi-cycle controller/datapath for RV32M DIV/DIVU/REM/REMU executed in the EX stage.

---
 rtl/rv_ex_pkg.sv | 26 ++
 rtl/div_step.sv | 27 ++
 rtl/ex_div_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_ex_div_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ex_pkg.sv
// Shared EX-stage definitions for the multi-cycle divider: operand width,
// M-extension funct3 codes and the divider sequencer state encoding.
package rv_ex_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic f3_is_signed(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic f3_is_rem(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide iteration: shift the next dividend bit into the
// partial remainder, compare against the divisor, subtract and emit a quotient bit.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    // One extra bit: the shifted remainder can exceed 2^XLEN when the divisor
    // has its top bit set, and dropping it would corrupt the comparison.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          ge;

    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        ge      = (shifted >= {1'b0, divisor});
        rem_out = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_out = {quo_in[XLEN-2:0], ge};
    end

endmodule

// File: rtl/ex_div_sequencer.sv
// EX-stage multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: stalls the front end
// while iterating, then pulses done with the signed-corrected result.
// Optional: EX_DIV_EARLY_OUT_EN sends divide-by-zero and signed overflow straight to DONE.
module ex_div_sequencer #(
    parameter int XLEN = rv_ex_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      result_rd
);
    import rv_ex_pkg::*;

    localparam int CNT_W = $clog2(XLEN);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [XLEN-1:0]   quo_reg, quo_next;
    logic [XLEN-1:0]   rem_reg, rem_next;
    logic [XLEN-1:0]   divisor_reg, divisor_next;
    logic              sign_a_reg, sign_a_next;
    logic              sign_b_reg, sign_b_next;
    logic              is_rem_reg, is_rem_next;
    logic [4:0]        rd_reg, rd_next;
    logic [XLEN-1:0]   result_hold_reg, result_hold_next;
    logic [4:0]        result_rd_reg, result_rd_next;

    logic [XLEN-1:0]   step_rem, step_quo;
    logic              in_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_value;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem_reg),
        .quo_in  (quo_reg),
        .divisor (divisor_reg),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Operand conditioning for the op presented in IDLE.
    always_comb begin
        in_signed = f3_is_signed(funct3);
        a_neg     = in_signed & rs1_data[XLEN-1];
        b_neg     = in_signed & rs2_data[XLEN-1];
        a_abs     = a_neg ? (~rs1_data + 1'b1) : rs1_data;
        b_abs     = b_neg ? (~rs2_data + 1'b1) : rs2_data;
    end

    // Sign correction; a zero divisor leaves the all-ones quotient untouched.
    always_comb begin
        quo_fix     = ((sign_a_reg ^ sign_b_reg) && (divisor_reg != '0)) ? (~quo_reg + 1'b1) : quo_reg;
        rem_fix     = sign_a_reg ? (~rem_reg + 1'b1) : rem_reg;
        final_value = is_rem_reg ? rem_fix : quo_fix;
    end

`ifdef EX_DIV_EARLY_OUT_EN
    logic early_div0, early_ovf;
    always_comb begin
        early_div0 = (rs2_data == '0);
        early_ovf  = in_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    end
`endif

    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        quo_next         = quo_reg;
        rem_next         = rem_reg;
        divisor_next     = divisor_reg;
        sign_a_next      = sign_a_reg;
        sign_b_next      = sign_b_reg;
        is_rem_next      = is_rem_reg;
        rd_next          = rd_reg;
        result_hold_next = result_hold_reg;
        result_rd_next   = result_rd_reg;
        stall            = 1'b0;
        done             = 1'b0;
        result           = result_hold_reg;
        result_rd        = result_rd_reg;

        case (state_reg)
            IDLE: begin
                // Gated by rst so stall reads 0 while reset is held.
                if (start && !flush && rst) begin
                    stall        = 1'b1;
                    divisor_next = b_abs;
                    sign_a_next  = a_neg;
                    sign_b_next  = b_neg;
                    is_rem_next  = f3_is_rem(funct3);
                    rd_next      = rd;
                    quo_next     = a_abs;
                    rem_next     = '0;
                    count_next   = CNT_W'(XLEN-1);
                    state_next   = CALC;
`ifdef EX_DIV_EARLY_OUT_EN
                    // Preload the magnitudes the full iteration would produce.
                    if (early_div0) begin
                        quo_next   = '1;
                        rem_next   = a_abs;
                        count_next = '0;
                        state_next = DONE;
                    end else if (early_ovf) begin
                        quo_next   = {1'b1, {(XLEN-1){1'b0}}};
                        rem_next   = '0;
                        count_next = '0;
                        state_next = DONE;
                    end
`endif
                end
            end

            CALC: begin
                if (flush) begin
                    count_next = '0;
                    state_next = IDLE;
                end else begin
                    stall      = 1'b1;
                    quo_next   = step_quo;
                    rem_next   = step_rem;
                    if (count_reg == '0) begin
                        state_next = DONE;
                    end else begin
                        count_next = count_reg - CNT_W'(1);
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
                if (!flush) begin
                    done             = 1'b1;
                    result           = final_value;
                    result_rd        = rd_reg;
                    result_hold_next = final_value;
                    result_rd_next   = rd_reg;
                end
            end

            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            quo_reg         <= '0;
            rem_reg         <= '0;
            divisor_reg     <= '0;
            sign_a_reg      <= 1'b0;
            sign_b_reg      <= 1'b0;
            is_rem_reg      <= 1'b0;
            rd_reg          <= '0;
            result_hold_reg <= '0;
            result_rd_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            quo_reg         <= quo_next;
            rem_reg         <= rem_next;
            divisor_reg     <= divisor_next;
            sign_a_reg      <= sign_a_next;
            sign_b_reg      <= sign_b_next;
            is_rem_reg      <= is_rem_next;
            rd_reg          <= rd_next;
            result_hold_reg <= result_hold_next;
            result_rd_reg   <= result_rd_next;
        end
    end

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Self-checking bench for ex_div_sequencer: directed corner cases plus random
// ops compared against a plain-arithmetic RV32M division model.
module tb_ex_div_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  result_rd;

    int n_cmp = 0;
    int n_bad = 0;

    ex_div_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd        (rd),
        .flush     (flush),
        .stall     (stall),
        .done      (done),
        .result    (result),
        .result_rd (result_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics from the ISA rules, using native arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        logic rem;
        logic [31:0] q;
        logic [31:0] r;
        sgn = (f3 == 3'b100) || (f3 == 3'b110);
        rem = f3[1];
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return rem ? r : q;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef EX_DIV_EARLY_OUT_EN
        logic sgn;
        sgn = (f3 == 3'b100) || (f3 == 3'b110);
        if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 1;
`endif
        return 33;
    endfunction

    // Called at posedge+1: presents the op in cycle 0 and follows it to done.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        logic [31:0] exp_res;
        int          exp_lat;
        int          cyc;
        bit          got;
        bit          stall_ok;
        exp_res  = ref_result(f3, a, b);
        exp_lat  = ref_latency(f3, a, b);
        start    = 1'b1;
        funct3   = f3;
        rs1_data = a;
        rs2_data = b;
        rd       = r;
        #1;
        check_eq("stall_cycle0", {31'd0, stall}, 32'd1);
        cyc      = 0;
        got      = 1'b0;
        stall_ok = 1'b1;
        while (!got && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
            else if (!stall) stall_ok = 1'b0;
        end
        check_eq("done_seen", {31'd0, got}, 32'd1);
        check_eq("stall_held", {31'd0, stall_ok}, 32'd1);
        check_eq("latency", 32'(cyc), 32'(exp_lat));
        check_eq("result", result, exp_res);
        check_eq("result_rd", {27'd0, result_rd}, {27'd0, r});
        check_eq("stall_in_done", {31'd0, stall}, 32'd0);
        $display("op f3=%b a=%h b=%h rd=%0d -> result=%h expected=%h latency=%0d", f3, a, b, r, result, exp_res, cyc);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check_eq("done_pulse", {31'd0, done}, 32'd0);
        check_eq("result_hold", result, exp_res);
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
    endtask

    initial begin
        int pulses;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        rst      = 1'b0;
        start    = 1'b0;
        funct3   = 3'b100;
        rs1_data = '0;
        rs2_data = '0;
        rd       = '0;
        flush    = 1'b0;
        #12;
        check_eq("reset_stall", {31'd0, stall}, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_result", result, 32'd0);
        check_eq("reset_rd", {27'd0, result_rd}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(3'b101, 32'd100, 32'd7, 5'd3);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd4);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5);
        run_op(3'b100, 32'd5, 32'd0, 5'd6);
        run_op(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd7);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        run_op(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 5'd10);
        run_op(3'b101, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd11);

        // Flush ten cycles into CALC: no done, stall drops in the flush cycle.
        start    = 1'b1;
        funct3   = 3'b100;
        rs1_data = 32'd1000;
        rs2_data = 32'd3;
        rd       = 5'd12;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        #1;
        check_eq("flush_stall", {31'd0, stall}, 32'd0);
        check_eq("flush_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
        #1;
        check_eq("post_flush_stall", {31'd0, stall}, 32'd0);
        count_done(40, pulses);
        check_eq("flush_no_done", 32'(pulses), 32'd0);
        $display("flush mid-calc: done pulses afterwards=%0d", pulses);
        run_op(3'b101, 32'd9, 32'd3, 5'd13);

        // Flush and start together in IDLE: nothing latched.
        start = 1'b1;
        flush = 1'b1;
        funct3 = 3'b101;
        rs1_data = 32'd50;
        rs2_data = 32'd5;
        #1;
        check_eq("idle_flush_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        count_done(40, pulses);
        check_eq("idle_flush_no_done", 32'(pulses), 32'd0);
        $display("flush with start in idle: done pulses=%0d", pulses);

        // Asynchronous reset mid-CALC.
        start    = 1'b1;
        funct3   = 3'b101;
        rs1_data = 32'd77;
        rs2_data = 32'd4;
        rd       = 5'd14;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_stall", {31'd0, stall}, 32'd0);
        check_eq("arst_done", {31'd0, done}, 32'd0);
        check_eq("arst_result", result, 32'd0);
        check_eq("arst_rd", {27'd0, result_rd}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_idle_stall", {31'd0, stall}, 32'd0);
        count_done(40, pulses);
        check_eq("post_rst_no_done", 32'(pulses), 32'd0);
        $display("async reset mid-calc: done pulses afterwards=%0d", pulses);

        for (int n = 0; n < 40; n++) begin
            rf3 = 3'b100 | 3'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                4: rb = $urandom | 32'h8000_0000;
                default: rb = $urandom;
            endcase
            run_op(rf3, ra, rb, 5'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
